// File: rtl/sap_clk_gate_ctrl.sv
// rtl/sap_clk_gate_ctrl.sv - idle-driven enable controller for one peripheral clock-gate cell
//
// Purpose:
//   Drives the en_i pin of the clock-gate primitive for one peripheral domain.
//   It counts consecutive idle cycles, asks the peripheral to quiesce, and
//   drops the enable only once the peripheral acknowledges. When work shows up,
//   it re-enables the clock and holds ready_o low for a fixed settling window.
//   The block runs on the ungated source clock.
//
// Ports:
//   clk_i           ungated source clock
//   rst_ni          asynchronous active-low reset
//   auto_en_i       auto-gating permitted; when low the domain is kept on
//   sw_en_i         software force-on
//   test_en_i       scan/test override, ORed straight into clk_en_o
//   busy_i          peripheral has outstanding work
//   wake_req_i      external request aimed at the gated domain
//   quiesce_req_o   ask the peripheral to reach a safe stop point
//   quiesce_ack_i   peripheral is stopped (held while quiesce_req_o is high)
//   clk_en_o        enable to the clock-gate cell
//   ready_o         domain clock running and stable
//   state_o         FSM state (ON=0, IDLE_WAIT=1, QUIESCE=2, OFF=3, WAKE=4)
//   gated_cycles_o  saturating count of cycles spent in OFF

module sap_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        auto_en_i,
  input  logic        sw_en_i,
  input  logic        test_en_i,
  input  logic        busy_i,
  input  logic        wake_req_i,
  output logic        quiesce_req_o,
  input  logic        quiesce_ack_i,
  output logic        clk_en_o,
  output logic        ready_o,
  output logic [2:0]  state_o,
  output logic [31:0] gated_cycles_o
);

  // One counter serves both the idle window and the wake window.
  localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_LAT) ? IDLE_CYCLES : WAKE_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_LAT - 1);

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_IDLE_WAIT = 3'd1,
    ST_QUIESCE   = 3'd2,
    ST_OFF       = 3'd3,
    ST_WAKE      = 3'd4
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_gated_cycles;
  logic [31:0]      w_gated_nxt;

  logic             w_wake;
  logic             w_cnt_zero;
  logic             w_en_fsm;
  logic             w_ready;
  logic             w_qreq;

  // Any of these means the domain must be (or stay) clocked.
  assign w_wake     = sw_en_i | wake_req_i | ~auto_en_i;
  assign w_cnt_zero = (r_cnt == '0);

  // Reset forces ON asynchronously. That re-enables the gate immediately,
  // which is the safe direction for the downstream cell.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_ON;
      r_cnt          <= '0;
      r_gated_cycles <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_gated_cycles <= w_gated_nxt;
    end
  end

  // The count saturates instead of wrapping.
  // Software can then tell a long-gated domain from a freshly reset one.
  always_comb begin
    w_gated_nxt = r_gated_cycles;
    if ((r_state == ST_OFF) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
      w_gated_nxt = r_gated_cycles + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_fsm    = 1'b1;
    w_ready     = 1'b0;
    w_qreq      = 1'b0;

    unique case (r_state)
      ST_ON: begin
        w_ready = 1'b1;
        if (!w_wake && !busy_i) begin
          w_state_nxt = ST_IDLE_WAIT;
          w_cnt_nxt   = IDLE_LOAD;
        end
      end

      ST_IDLE_WAIT: begin
        w_ready = 1'b1;
        if (w_wake || busy_i) begin
          w_state_nxt = ST_ON;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_QUIESCE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      ST_QUIESCE: begin
        w_qreq = 1'b1;
        // New work wins over a same-cycle ack, so the clock never drops
        // under a request that has just arrived.
        if (w_wake || busy_i) begin
          w_state_nxt = ST_ON;
        end else if (quiesce_ack_i) begin
          w_state_nxt = ST_OFF;
        end
      end

      ST_OFF: begin
        // The peripheral is stopped, so busy_i carries no meaning here.
        w_en_fsm = 1'b0;
        w_qreq   = 1'b1;
        if (w_wake) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = WAKE_LOAD;
        end
      end

      ST_WAKE: begin
        // The wake window is non-abortable, so the clock gets its full
        // settling time before ready_o rises.
        if (w_cnt_zero) begin
          w_state_nxt = ST_ON;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_ON;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign clk_en_o       = w_en_fsm | test_en_i;
  assign ready_o        = w_ready;
  assign quiesce_req_o  = w_qreq;
  assign state_o        = r_state;
  assign gated_cycles_o = r_gated_cycles;

endmodule
